sseg_display_arbiter: RTL and testbench

- Shares the board's 4-digit seven-segment display between two requesters:
  - Channel 0: the switch/button capture path.
  - Channel 1: the status/error path.
- Grants display ownership with a req/gnt handshake and latches a 16-bit hex value from the winner.
- Holds ownership for a fixed number of scan frames, then reopens arbitration.
- Drives the time-multiplexed digit scan (an/sseg/dp) to the board pins.

---
 rtl/sseg_display_arbiter_if.sv | 25 ++
 rtl/sseg_display_arbiter.sv | 147 ++++++++++++++
 tb/tb_sseg_display_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sseg_display_arbiter_if.sv
// Display-sharing bus between the two requesters and the seven-segment arbiter.
// The master side drives requests and data; the slave side (arbiter) drives grants and display pins.
interface sseg_display_arbiter_if;
  logic        req0;
  logic [15:0] data0;
  logic        gnt0;
  logic        req1;
  logic [15:0] data1;
  logic        gnt1;
  logic [6:0]  sseg;
  logic [3:0]  an;
  logic        dp;
  logic        owner;
  logic        busy;

  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, sseg, an, dp, owner, busy
  );

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, sseg, an, dp, owner, busy
  );
endinterface

// File: rtl/sseg_display_arbiter.sv
// Round-robin owner of the 4-digit seven-segment display: grants, holds for HOLD_FRAMES scan frames, drives the scan.
// Optional SSEG_OWNER_DP_EN: leftmost decimal point marks channel 1 ownership.
module sseg_display_arbiter #(
  parameter int SCAN_W      = 18,
  parameter int HOLD_FRAMES = 4
) (
  input logic                   clk,
  input logic                   rst,
  sseg_display_arbiter_if.slave bus
);
  localparam int HOLD_EFF = (HOLD_FRAMES < 1) ? 1 : HOLD_FRAMES;
  localparam int HOLD_W   = $clog2(HOLD_EFF + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] OPEN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [SCAN_W-1:0] scan_q,  scan_d;
  logic [HOLD_W-1:0] hold_q,  hold_d;
  logic [15:0]       data_q,  data_d;
  logic              owner_q, owner_d;
  logic              last_q,  last_d;
  logic              gnt0_q,  gnt0_d;
  logic              gnt1_q,  gnt1_d;
  logic [3:0]        an_q,    an_d;
  logic [6:0]        sseg_q,  sseg_d;
  logic              dp_q,    dp_d;

  logic       wrap;
  logic       expire;
  logic       arb_en;
  logic       pick0;
  logic       pick1;
  logic [1:0] idx;
  logic [3:0] nib;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // The edge that ends a hold also arbitrates, so a waiting requester is granted exactly one hold period later.
  assign wrap   = &scan_q;
  assign expire = (state_q == HOLD) && wrap && (hold_q == HOLD_W'(1));
  assign arb_en = (state_q != HOLD) || expire;
  assign pick0  = arb_en && bus.req0 && (!bus.req1 || last_q);
  assign pick1  = arb_en && bus.req1 && (!bus.req0 || !last_q);

  assign idx = scan_q[SCAN_W-1 -: 2];
  assign nib = data_q[{idx, 2'b00} +: 4];

  always_comb begin
    state_d = state_q;
    scan_d  = scan_q + SCAN_W'(1);
    hold_d  = hold_q;
    data_d  = data_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;

    if (pick0 || pick1) begin
      gnt0_d  = pick0;
      gnt1_d  = pick1;
      data_d  = pick1 ? bus.data1 : bus.data0;
      owner_d = pick1;
      last_d  = pick1;
      scan_d  = '0;
      hold_d  = HOLD_W'(HOLD_EFF);
      state_d = HOLD;
    end else if ((state_q == HOLD) && wrap) begin
      hold_d = hold_q - HOLD_W'(1);
      if (hold_q == HOLD_W'(1)) begin
        state_d = OPEN;
      end
    end

    if (state_q == IDLE) begin
      an_d   = 4'b1111;
      sseg_d = 7'b1111111;
    end else begin
      an_d   = ~(4'b0001 << idx);
      sseg_d = decode(nib);
    end

`ifdef SSEG_OWNER_DP_EN
    dp_d = !((state_q != IDLE) && (idx == 2'd3) && owner_q);
`else
    dp_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      scan_q  <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      an_q    <= 4'b1111;
      sseg_q  <= 7'b1111111;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      an_q    <= an_d;
      sseg_q  <= sseg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.an    = an_q;
  assign bus.sseg  = sseg_q;
  assign bus.dp    = dp_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q == HOLD);
endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Directed bench for sseg_display_arbiter with SCAN_W=4 (16-cycle frame) and HOLD_FRAMES=2 (32-cycle hold).
module tb_sseg_display_arbiter;
  logic clk = 1'b0;
  logic rst;

  sseg_display_arbiter_if b ();

  sseg_display_arbiter #(.SCAN_W(4), .HOLD_FRAMES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  int n_tot  = 0;
  int n_pass = 0;
  int took;
  int ch;
  int last_ch;

  typedef struct {
    int             ch;
    logic [15:0]    data;
    logic [3:0][6:0] seg;
  } vec_t;

  vec_t vecs [4];
  logic [3:0][6:0] seg_1234;
  logic [3:0][6:0] seg_fedc;

  function automatic vec_t mk(input int c, input logic [15:0] d,
                              input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
    vec_t v;
    v.ch   = c;
    v.data = d;
    v.seg  = {s3, s2, s1, s0};
    return v;
  endfunction

  function automatic logic exp_dp(input int c, input int idx);
`ifdef SSEG_OWNER_DP_EN
    return !(c == 1 && idx == 3);
`else
    return 1'b1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_digit(input string tag, input int c, input logic [3:0][6:0] seg, input int owner_ch);
    int idx;
    logic [3:0] an_exp;
    idx    = (c - 1) / 4;
    an_exp = 4'b1111 ^ (4'b0001 << idx);
    check({tag, " an"},   {28'd0, b.an},   {28'd0, an_exp});
    check({tag, " sseg"}, {25'd0, b.sseg}, {25'd0, seg[idx]});
    check({tag, " dp"},   {31'd0, b.dp},   {31'd0, exp_dp(owner_ch, idx)});
  endtask

  // Ticks cycles 17..32 after a grant; busy must fall exactly at cycle 32.
  task automatic hold_rest(input string tag);
    for (int c = 17; c <= 32; c++) begin
      tick();
      check({tag, " busy"}, {31'd0, b.busy}, (c < 32) ? 32'd1 : 32'd0);
      check({tag, " no gnt"}, {30'd0, b.gnt0, b.gnt1}, 32'd0);
    end
  endtask

  task automatic wait_gnt(input int c, input int budget, output int t);
    t = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if ((c == 0 && b.gnt0) || (c == 1 && b.gnt1)) begin
        t = i;
        break;
      end
    end
  endtask

  task automatic wait_any(input int budget, output int t, output int c);
    t = -1;
    c = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (b.gnt0 || b.gnt1) begin
        t = i;
        c = b.gnt1 ? 1 : 0;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [14:0] idle_exp;
    vecs[0] = mk(0, 16'h3210, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000);
    vecs[1] = mk(1, 16'h7654, 7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001);
    vecs[2] = mk(0, 16'hBA98, 7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000);
    vecs[3] = mk(1, 16'hFEDC, 7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110);
    seg_1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    seg_fedc = {7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110};
    idle_exp = {4'hF, 7'h7F, 1'b1, 3'b000};

    // Reset and idle display
    rst     = 1'b0;
    b.req0  = 1'b0;
    b.req1  = 1'b0;
    b.data0 = 16'h0;
    b.data1 = 16'h0;
    repeat (5) tick();
    check("rst an",    {28'd0, b.an},    32'hF);
    check("rst sseg",  {25'd0, b.sseg},  32'h7F);
    check("rst dp",    {31'd0, b.dp},    32'd1);
    check("rst gnt",   {30'd0, b.gnt0, b.gnt1}, 32'd0);
    check("rst owner", {31'd0, b.owner}, 32'd0);
    check("rst busy",  {31'd0, b.busy},  32'd0);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("idle outputs", {17'd0, b.an, b.sseg, b.dp, b.busy, b.gnt0, b.gnt1}, {17'd0, idle_exp});
    end

    // Table: one grant per record, full scan, exact hold length
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].ch == 0) begin b.data0 = vecs[v].data; b.req0 = 1'b1; end
      else                 begin b.data1 = vecs[v].data; b.req1 = 1'b1; end
      wait_gnt(vecs[v].ch, 3, took);
      check("tbl grant latency", took, 32'd1);
      b.req0 = 1'b0;
      b.req1 = 1'b0;
      check("tbl owner", {31'd0, b.owner}, vecs[v].ch);
      check("tbl busy",  {31'd0, b.busy},  32'd1);
      for (int c = 1; c <= 16; c++) begin
        tick();
        chk_digit("tbl", c, vecs[v].seg, vecs[v].ch);
      end
      hold_rest("tbl");
    end

    // Blocked request: req1 raised 5 cycles into channel 0's hold
    b.data0 = 16'h1234;
    b.req0  = 1'b1;
    wait_gnt(0, 3, took);
    check("blk gnt0 latency", took, 32'd1);
    b.req0 = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (c <= 16) chk_digit("blk 1234", c, seg_1234, 0);
      if (c == 5) begin
        b.data1 = 16'hFEDC;
        b.req1  = 1'b1;
      end
      if (c < 32) begin
        check("blk waiting", {30'd0, b.gnt1, b.busy}, 32'd1);
      end else begin
        check("blk gnt1 at 32", {31'd0, b.gnt1},  32'd1);
        check("blk owner",      {31'd0, b.owner}, 32'd1);
      end
    end
    b.req1 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk_digit("blk fedc", c, seg_fedc, 1);
    end
    hold_rest("blk");

    // Round robin from reset release with both requesters contending
    rst     = 1'b0;
    b.req0  = 1'b1;
    b.req1  = 1'b1;
    b.data0 = 16'hAAAA;
    b.data1 = 16'h5555;
    tick();
    tick();
    rst     = 1'b1;
    last_ch = 0;
    for (int g = 0; g < 4; g++) begin
      if (g > 0) begin
        tick();
        if (last_ch == 0) b.req0 = 1'b1;
        else              b.req1 = 1'b1;
      end
      wait_any(40, took, ch);
      check("rr spacing", took + ((g > 0) ? 1 : 0), (g == 0) ? 32'd1 : 32'd32);
      check("rr channel", ch, g % 2);
      if (ch == 0) b.req0 = 1'b0;
      else if (ch == 1) b.req1 = 1'b0;
      last_ch = ch;
    end

    // Reset 10 cycles into channel 1's hold
    repeat (10) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst an",    {28'd0, b.an},    32'hF);
    check("midrst sseg",  {25'd0, b.sseg},  32'h7F);
    check("midrst busy",  {31'd0, b.busy},  32'd0);
    check("midrst owner", {31'd0, b.owner}, 32'd0);
    check("midrst gnt",   {30'd0, b.gnt0, b.gnt1}, 32'd0);
    b.req0 = 1'b1;
    b.req1 = 1'b1;
    wait_any(3, took, ch);
    check("midrst first latency", took, 32'd1);
    check("midrst first channel", ch, 32'd0);
    b.req0 = 1'b0;
    b.req1 = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
